// File: rtl/multi_port_queue_if.sv
// Handshake bundle for multi_port_queue.
// The producer/consumer side uses the master modport and the queue uses the slave modport.
interface multi_port_queue_if #(
  parameter int ENQ_N = 2,
  parameter int DEQ_N = 2,
  parameter int WIDTH = 32
);
  logic [ENQ_N-1:0] enq_valid;
  logic [WIDTH-1:0] enq_data [ENQ_N];
  logic             enq_ready;
  logic [DEQ_N-1:0] deq_valid;
  logic [WIDTH-1:0] deq_data [DEQ_N];
  logic [DEQ_N-1:0] deq_pop;

  modport master (
    output enq_valid, enq_data, deq_pop,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_pop,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/multi_port_queue.sv
// Multi-lane circular queue: ENQ_N compacting enqueue lanes, DEQ_N dequeue lanes.
// Enqueue is all-or-nothing against the pre-dequeue free space; the element count
// alone decides full/empty, so head/tail equality is never ambiguous.
// Optional peak-occupancy register enabled by macro MULTI_PORT_QUEUE_WATERMARK_EN;
// without it max_count reads 0.
module multi_port_queue #(
  parameter int DEPTH_BITS = 4,
  parameter int ENQ_N      = 2,
  parameter int DEQ_N      = 2,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  multi_port_queue_if.slave     q,
  output logic [DEPTH_BITS:0]   freespace,
  output logic [DEPTH_BITS:0]   elemcount,
  output logic [DEPTH_BITS:0]   max_count
);

  localparam int DEPTH    = 1 << DEPTH_BITS;
  localparam int CNT_W    = DEPTH_BITS + 1;
  localparam int LANE_MAX = (ENQ_N > DEQ_N) ? ENQ_N : DEQ_N;
  localparam int PC_W     = $clog2(LANE_MAX) + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] head_ptr;
  logic [DEPTH_BITS-1:0] tail_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [CNT_W-1:0]      n_enq_ext;
  logic [CNT_W-1:0]      n_enq_acc;
  logic [CNT_W-1:0]      n_deq;
  logic [PC_W-1:0]       n_enq;
  logic [PC_W-1:0]       enq_acc;
  logic [PC_W-1:0]       pop_run;
  logic [PC_W-1:0]       enq_off [ENQ_N];
  logic                  pop_chain;
  logic                  accept;
  logic                  wr_en;

  // Compaction: each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    enq_acc = '0;
    for (int i = 0; i < ENQ_N; i++) begin
      enq_off[i] = enq_acc;
      if (q.enq_valid[i]) enq_acc = enq_acc + PC_W'(1);
    end
    n_enq = enq_acc;
  end

  // Pop run length: consecutive ones from lane 0; anything above the first zero is ignored.
  always_comb begin
    pop_chain = 1'b1;
    pop_run   = '0;
    for (int j = 0; j < DEQ_N; j++) begin
      pop_chain = pop_chain & q.deq_pop[j];
      if (pop_chain) pop_run = pop_run + PC_W'(1);
    end
  end

  // Acceptance and next-count arithmetic; a same-cycle pop never creates room for a push.
  always_comb begin
    n_enq_ext  = CNT_W'(n_enq);
    accept     = (n_enq_ext <= freespace);
    wr_en      = rst & accept & ~flush;
    n_enq_acc  = accept ? n_enq_ext : '0;
    n_deq      = (CNT_W'(pop_run) > count) ? count : CNT_W'(pop_run);
    count_next = flush ? '0 : (count + n_enq_acc - n_deq);
  end

  // Read side: lane j shows the j-th oldest entry, valid only while it exists.
  always_comb begin
    q.deq_valid = '0;
    for (int j = 0; j < DEQ_N; j++) begin
      q.deq_valid[j] = (count > CNT_W'(j));
      q.deq_data[j]  = mem[tail_ptr + DEPTH_BITS'(j)];
    end
  end

  assign q.enq_ready = accept;
  assign freespace   = CNT_W'(DEPTH) - count;
  assign elemcount   = count;

  // Storage writes; contents are don't-care until written so there is no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < ENQ_N; i++) begin
        if (q.enq_valid[i]) mem[head_ptr + DEPTH_BITS'(enq_off[i])] <= q.enq_data[i];
      end
    end
  end

  // Pointer and count state; flush keeps head and drops everything behind it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      tail_ptr <= head_ptr;
      count    <= '0;
    end else begin
      head_ptr <= head_ptr + DEPTH_BITS'(n_enq_acc);
      tail_ptr <= tail_ptr + DEPTH_BITS'(n_deq);
      count    <= count_next;
    end
  end

`ifdef MULTI_PORT_QUEUE_WATERMARK_EN
  logic [CNT_W-1:0] peak_q;

  // Peak occupancy tracks count_next in the same edge; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
    end else if (count_next > peak_q) begin
      peak_q <= count_next;
    end
  end

  assign max_count = peak_q;
`else
  assign max_count = '0;
`endif

endmodule

// File: tb/tb_multi_port_queue.sv
// Scoreboard bench for multi_port_queue (DEPTH_BITS=4, ENQ_N=DEQ_N=2, WIDTH=32).
// Accepted enqueue data is pushed into exp_q in lane order; a negedge monitor pops
// and compares every entry the queue actually hands out.
module tb_multi_port_queue;

  logic clk;
  logic rst;
  logic flush;
  logic [4:0] freespace;
  logic [4:0] elemcount;
  logic [4:0] max_count;

  int checks;
  int errors;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic        mon_chain;

  multi_port_queue_if #(.ENQ_N(2), .DEQ_N(2), .WIDTH(32)) q ();

  multi_port_queue #(.DEPTH_BITS(4), .ENQ_N(2), .DEQ_N(2), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .q         (q),
    .freespace (freespace),
    .elemcount (elemcount),
    .max_count (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each lane that is really popped this cycle against the scoreboard.
  always @(negedge clk) begin
    if (rst && !flush) begin
      mon_chain = 1'b1;
      for (int j = 0; j < 2; j++) begin
        mon_chain = mon_chain & q.deq_pop[j];
        if (mon_chain && q.deq_valid[j]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_lane%0d got %0h expected no entry", j, q.deq_data[j]);
          end else begin
            mon_exp = exp_q.pop_front();
            if (q.deq_data[j] !== mon_exp) begin
              errors++;
              $display("FAIL pop_lane%0d got %0h expected %0h", j, q.deq_data[j], mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] pop, input logic fl, input logic acc);
    @(posedge clk);
    #1;
    q.enq_valid   = ev;
    q.enq_data[0] = d0;
    q.enq_data[1] = d1;
    q.deq_pop     = pop;
    flush         = fl;
    if (fl) begin
      exp_q.delete();
    end else if (acc) begin
      if (ev[0]) exp_q.push_back(d0);
      if (ev[1]) exp_q.push_back(d1);
    end
    #1;
  endtask

  task automatic idle();
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  logic [31:0] exp_peak;

  initial begin
    checks = 0;
    errors = 0;
`ifdef MULTI_PORT_QUEUE_WATERMARK_EN
    exp_peak = 32'd10;
`else
    exp_peak = 32'd0;
`endif
    // Reset with enqueue requests asserted: they must be ignored.
    rst           = 1'b0;
    flush         = 1'b0;
    q.enq_valid   = 2'b11;
    q.enq_data[0] = 32'h1111;
    q.enq_data[1] = 32'h2222;
    q.deq_pop     = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    q.enq_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_elemcount", 32'(elemcount), 32'd0);
    chk("rst_freespace", 32'(freespace), 32'd16);
    chk("rst_deq_valid", 32'(q.deq_valid), 32'd0);
    chk("rst_enq_ready", 32'(q.enq_ready), 32'd1);
    chk("rst_max_count", 32'(max_count), 32'd0);

    // Sparse compaction: lane 1 only lands in the oldest slot.
    cyc(2'b10, 32'hDEAD, 32'hA5, 2'b00, 1'b0, 1'b1);
    idle();
    chk("sparse_deq_valid", 32'(q.deq_valid), 32'd1);
    chk("sparse_deq_data0", q.deq_data[0], 32'hA5);
    chk("sparse_elemcount", 32'(elemcount), 32'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0);
    idle();
    chk("sparse_drained", 32'(elemcount), 32'd0);

    // Fill to 15, reject a two-lane push, accept a single one to reach full.
    for (int k = 0; k < 7; k++)
      cyc(2'b11, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 2'b00, 1'b0, 1'b1);
    cyc(2'b01, 32'h10E, 32'h0, 2'b00, 1'b0, 1'b1);
    cyc(2'b11, 32'hBAD0, 32'hBAD1, 2'b00, 1'b0, 1'b0);
    chk("bp_enq_ready_lo", 32'(q.enq_ready), 32'd0);
    chk("bp_elemcount15", 32'(elemcount), 32'd15);
    chk("bp_freespace1", 32'(freespace), 32'd1);
    cyc(2'b01, 32'h7, 32'h0, 2'b00, 1'b0, 1'b1);
    chk("bp_enq_ready_hi", 32'(q.enq_ready), 32'd1);
    chk("bp_no_write", 32'(elemcount), 32'd15);
    cyc(2'b01, 32'hBAD2, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("full_elemcount", 32'(elemcount), 32'd16);
    chk("full_freespace", 32'(freespace), 32'd0);
    chk("full_enq_ready", 32'(q.enq_ready), 32'd0);
    for (int k = 0; k < 7; k++) cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    idle();
    chk("drain_elemcount", 32'(elemcount), 32'd0);

    // Move pointers to 15 with steady two-in/two-out traffic.
    cyc(2'b11, 32'h200, 32'h201, 2'b00, 1'b0, 1'b1);
    for (int k = 1; k < 7; k++)
      cyc(2'b11, 32'h200 + 32'(2*k), 32'h201 + 32'(2*k), 2'b11, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("steady_elemcount", 32'(elemcount), 32'd2);
    chk("steady_deq_valid", 32'(q.deq_valid), 32'd3);

    // Wrap: 0x1,0x2 land in slots 15 and 0; then push 0x3,0x4 while popping them.
    cyc(2'b11, 32'h1, 32'h2, 2'b00, 1'b0, 1'b1);
    chk("wrap_pre_empty", 32'(elemcount), 32'd0);
    cyc(2'b11, 32'h3, 32'h4, 2'b11, 1'b0, 1'b1);
    chk("wrap_deq_valid", 32'(q.deq_valid), 32'd3);
    chk("wrap_deq_data0", q.deq_data[0], 32'h1);
    chk("wrap_deq_data1", q.deq_data[1], 32'h2);
    chk("wrap_enq_ready", 32'(q.enq_ready), 32'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("wrap_elemcount", 32'(elemcount), 32'd2);

    // Enqueue into empty with a pop pops nothing; clamping and non-thermometer pops.
    cyc(2'b01, 32'h5, 32'h0, 2'b11, 1'b0, 1'b1);
    chk("empty_pop_pre", 32'(elemcount), 32'd0);
    cyc(2'b00, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0);
    chk("no_bypass_count", 32'(elemcount), 32'd1);
    chk("no_bypass_valid", 32'(q.deq_valid), 32'd1);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("nonthermo_count", 32'(elemcount), 32'd1);
    idle();
    chk("clamp_count", 32'(elemcount), 32'd0);
    chk("clamp_deq_valid", 32'(q.deq_valid), 32'd0);

    // Asynchronous reset with entries present, released mid-cycle.
    cyc(2'b11, 32'hE0, 32'hE1, 2'b00, 1'b0, 1'b1);
    idle();
    chk("prereset_count", 32'(elemcount), 32'd2);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #3;
    chk("async_rst_count", 32'(elemcount), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to 10 and flush with a same-cycle two-lane push.
    for (int k = 0; k < 5; k++)
      cyc(2'b11, 32'h300 + 32'(2*k), 32'h301 + 32'(2*k), 2'b00, 1'b0, 1'b1);
    cyc(2'b11, 32'hF0, 32'hF1, 2'b11, 1'b1, 1'b0);
    chk("preflush_count", 32'(elemcount), 32'd10);
    idle();
    chk("flush_elemcount", 32'(elemcount), 32'd0);
    chk("flush_deq_valid", 32'(q.deq_valid), 32'd0);
    chk("flush_freespace", 32'(freespace), 32'd16);
    chk("flush_max_count", 32'(max_count), exp_peak);
    cyc(2'b11, 32'hAA, 32'hBB, 2'b00, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
    chk("postflush_count", 32'(elemcount), 32'd2);
    chk("postflush_valid", 32'(q.deq_valid), 32'd3);
    idle();
    idle();
    chk("final_elemcount", 32'(elemcount), 32'd0);
    chk("final_max_count", 32'(max_count), exp_peak);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
